kogge_stone_subtractor_pipe: RTL

- Pipelined N-bit subtractor built on a Kogge-Stone parallel-prefix borrow network.
- Computes DIFF = A - B - bin and reports borrow-out, signed overflow and zero flags.
- It is the inverse-operation companion of the team's Kogge-Stone adder.
- Sits in arithmetic datapaths that need registered, back-pressurable subtraction with a valid/ready handshake on both sides.

---
 rtl/kogge_stone_subtractor_pipe.sv | 138 +++++++++++++
 1 files changed

// File: rtl/kogge_stone_subtractor_pipe.sv
// kogge_stone_subtractor_pipe: registered A - B - bin on a Kogge-Stone
// borrow network, one prefix level per stage, valid/ready on both sides.
module kogge_stone_subtractor_pipe #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         bout,
    output logic         ovf,
    output logic         zero
);

    localparam int LVL = $clog2(N);

    // whole pipe freezes while a result waits downstream
    logic stall;

    // stage k state: k = 0 is the operand stage, k >= 1 follows prefix level k
    logic         vld [0:LVL];
    logic [N-1:0] gg  [0:LVL];
    logic [N-1:0] pg  [0:LVL];
    logic [N-1:0] pb  [0:LVL];
    logic         ci  [0:LVL];

    // operand-stage inputs
    logic [N-1:0] g_in;
    logic [N-1:0] p_in;
    logic         cin;

    // prefix-level results before registering
    logic [N-1:0] gg_nxt [1:LVL];
    logic [N-1:0] pg_nxt [1:LVL];

    // final-stage values before registering
    logic [N:0]   c;
    logic [N-1:0] diff_nxt;
    logic         bout_nxt;
    logic         ovf_nxt;
    logic         zero_nxt;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // subtraction as A + ~B + ~bin; carry-in folded into bit 0 generate
    always_comb begin
        p_in    = a ^ ~b;
        cin     = ~bin;
        g_in    = a & ~b;
        g_in[0] = g_in[0] | (p_in[0] & cin);
    end

    // operand stage: capture per-bit generate/propagate and carry-in
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld[0] <= 1'b0;
            gg[0]  <= '0;
            pg[0]  <= '0;
            pb[0]  <= '0;
            ci[0]  <= 1'b0;
        end else if (!stall) begin
            vld[0] <= in_valid;
            gg[0]  <= g_in;
            pg[0]  <= p_in;
            pb[0]  <= p_in;
            ci[0]  <= cin;
        end
    end

    // Kogge-Stone level k combines each bit with the one 2^(k-1) below
    always_comb begin
        for (int k = 1; k <= LVL; k++) begin
            gg_nxt[k] = gg[k-1];
            pg_nxt[k] = pg[k-1];
            for (int i = (1 << (k - 1)); i < N; i++) begin
                gg_nxt[k][i] = gg[k-1][i]
                             | (pg[k-1][i] & gg[k-1][i - (1 << (k - 1))]);
                pg_nxt[k][i] = pg[k-1][i]
                             & pg[k-1][i - (1 << (k - 1))];
            end
        end
    end

    // prefix stages: one level each, bit propagates and cin ride along
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 1; k <= LVL; k++) begin
                vld[k] <= 1'b0;
                gg[k]  <= '0;
                pg[k]  <= '0;
                pb[k]  <= '0;
                ci[k]  <= 1'b0;
            end
        end else if (!stall) begin
            for (int k = 1; k <= LVL; k++) begin
                vld[k] <= vld[k-1];
                gg[k]  <= gg_nxt[k];
                pg[k]  <= pg_nxt[k];
                pb[k]  <= pb[k-1];
                ci[k]  <= ci[k-1];
            end
        end
    end

    // group generates are the carries into the next bit up
    always_comb begin
        c        = {gg[LVL], ci[LVL]};
        diff_nxt = pb[LVL] ^ c[N-1:0];
        bout_nxt = ~c[N];
        ovf_nxt  = c[N] ^ c[N-1];
        zero_nxt = ~|diff_nxt;
    end

    // result stage: held stable while downstream is not ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (!stall) begin
            out_valid <= vld[LVL];
            diff      <= diff_nxt;
            bout      <= bout_nxt;
            ovf       <= ovf_nxt;
            zero      <= zero_nxt;
        end
    end

endmodule
